serial_deserializer: RTL and testbench

//   Receive side of the 4-bit serial link. Collects bits shifted out LSB-first by the parallel-load

---
 rtl/serial_deserializer_pkg.sv | 9 +
 rtl/serial_deserializer_if.sv | 32 +++
 rtl/serial_deserializer_fifo.sv | 88 ++++++++
 rtl/serial_deserializer.sv | 91 +++++++++
 tb/tb_serial_deserializer.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/serial_deserializer_pkg.sv
// Types and constants shared by the serial link transmit and receive blocks.
package serial_pkg;

    localparam int SER_WIDTH = 4;
    localparam int SER_DEPTH = 4;

    typedef logic [SER_WIDTH-1:0] ser_word_t;

endpackage

// File: rtl/serial_deserializer_if.sv
// Bundle of the serial receive inputs, the consumer handshake and the status outputs.
interface serial_deserializer_if
    import serial_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH,
    parameter int DEPTH = SER_DEPTH
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic             rx;
    logic             rx_en;
    logic             rx_clear;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic [LVL_W-1:0] level;
    logic [CNT_W-1:0] bit_cnt;
    logic             overflow;
    logic             overflow_clr;

    modport master (
        output rx, rx_en, rx_clear, m_ready, overflow_clr,
        input  m_data, m_valid, level, bit_cnt, overflow
    );

    modport slave (
        input  rx, rx_en, rx_clear, m_ready, overflow_clr,
        output m_data, m_valid, level, bit_cnt, overflow
    );

endinterface

// File: rtl/serial_deserializer_fifo.sv
// Show-ahead synchronous FIFO; the head word is held in a register so dout has no
// combinational path from din.
module sync_fifo
    import serial_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH,
    parameter int DEPTH = SER_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    output logic                       full,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic [WIDTH-1:0] r_dout;

    logic             w_full;
    logic             w_empty;
    logic             w_do_pop;
    logic             w_do_push;
    logic [PTR_W-1:0] w_rd_next;

    assign w_full    = (r_level == LVL_W'(DEPTH));
    assign w_empty   = (r_level == '0);
    assign w_do_pop  = pop && !w_empty;
    // A pop on the same edge frees the slot the push needs.
    assign w_do_push = push && (!w_full || w_do_pop);
    assign w_rd_next = r_rd_ptr + PTR_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            if (w_do_push && !w_do_pop) begin
                r_level <= r_level + LVL_W'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_level <= r_level - LVL_W'(1);
            end
        end
    end

    // Head register: bypass the incoming word when it becomes the head, otherwise
    // fetch the entry behind the one being popped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dout <= '0;
        end else if (w_do_push && (w_empty || (r_level == LVL_W'(1) && w_do_pop))) begin
            r_dout <= din;
        end else if (w_do_pop && (r_level > LVL_W'(1))) begin
            r_dout <= r_mem[w_rd_next];
        end
    end

    assign full  = w_full;
    assign empty = w_empty;
    assign level = r_level;
    assign dout  = r_dout;

endmodule

// File: rtl/serial_deserializer.sv
// Serial receiver: assembles LSB-first bits into words and queues them for a
// valid/ready consumer, flagging words lost to a full queue.
module serial_deserializer
    import serial_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH,
    parameter int DEPTH = SER_DEPTH
) (
    input  logic                 clk,
    input  logic                 reset,
    serial_deserializer_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_shift;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             r_overflow;

    logic             w_sample;
    logic             w_last;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [WIDTH-1:0] w_word;
    logic [WIDTH-1:0] w_dout;
    logic [LVL_W-1:0] w_level;

    assign w_sample = bus.rx_en && !bus.rx_clear;
    assign w_last   = (r_bit_cnt == CNT_W'(WIDTH - 1));
    assign w_push   = w_sample && w_last;
    assign w_pop    = !w_empty && bus.m_ready;

    // Word as it stands after merging the current rx bit into its slot.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_merge
            assign w_word[gi] = (r_bit_cnt == CNT_W'(gi)) ? bus.rx : r_shift[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (bus.rx_clear) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_sample) begin
            if (w_last) begin
                r_shift   <= '0;
                r_bit_cnt <= '0;
            end else begin
                r_shift   <= w_word;
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end else if (bus.overflow_clr) begin
            r_overflow <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .din   (w_word),
        .full  (w_full),
        .pop   (w_pop),
        .dout  (w_dout),
        .empty (w_empty),
        .level (w_level)
    );

    assign bus.m_data   = w_dout;
    assign bus.m_valid  = !w_empty;
    assign bus.level    = w_level;
    assign bus.bit_cnt  = r_bit_cnt;
    assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_serial_deserializer.sv
// Bench for serial_deserializer: a reference model at each falling edge tracks the
// assembler and a scoreboard queue of expected words.
module tb_serial_deserializer;
    import serial_pkg::*;

    localparam int W = 4;
    localparam int D = 4;

    logic clk;
    logic reset;

    serial_deserializer_if #(.WIDTH(W), .DEPTH(D)) bus ();

    serial_deserializer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    ser_word_t sb[$];
    int        m_cnt  = 0;
    ser_word_t m_word = '0;
    logic      m_ovf  = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Compare DUT state against the model, then advance the model by the inputs
    // that the next rising edge will sample.
    always @(negedge clk) begin
        if (!reset) begin
            sb.delete();
            m_cnt  = 0;
            m_word = '0;
            m_ovf  = 1'b0;
        end else begin
            bit        do_pop;
            bit        got;
            bit        dropped;
            ser_word_t w;
            check_val("m_valid", 32'(bus.m_valid), 32'(sb.size() != 0));
            check_val("level", 32'(bus.level), 32'(sb.size()));
            check_val("bit_cnt", 32'(bus.bit_cnt), 32'(m_cnt));
            check_val("overflow", 32'(bus.overflow), 32'(m_ovf));
            if (sb.size() != 0) begin
                check_val("m_data", 32'(bus.m_data), 32'(sb[0]));
                $display("head word %0h level %0d", bus.m_data, bus.level);
            end
            do_pop  = (sb.size() != 0) && bus.m_ready;
            got     = 1'b0;
            dropped = 1'b0;
            w       = '0;
            if (bus.rx_clear) begin
                m_cnt  = 0;
                m_word = '0;
            end else if (bus.rx_en) begin
                m_word[m_cnt] = bus.rx;
                if (m_cnt == W - 1) begin
                    got    = 1'b1;
                    w      = m_word;
                    m_cnt  = 0;
                    m_word = '0;
                end else begin
                    m_cnt++;
                end
            end
            if (do_pop) void'(sb.pop_front());
            if (got) begin
                if (sb.size() < D) sb.push_back(w);
                else dropped = 1'b1;
            end
            if (dropped) m_ovf = 1'b1;
            else if (bus.overflow_clr) m_ovf = 1'b0;
        end
    end

    task automatic drive(input logic en, input logic b, input logic clr,
                         input logic rdy, input logic oclr);
        @(posedge clk);
        #1;
        bus.rx_en        = en;
        bus.rx           = b;
        bus.rx_clear     = clr;
        bus.m_ready      = rdy;
        bus.overflow_clr = oclr;
    endtask

    task automatic send_word(input ser_word_t w, input logic rdy);
        for (int i = 0; i < W; i++) drive(1'b1, w[i], 1'b0, rdy, 1'b0);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    initial begin
        reset            = 1'b0;
        bus.rx           = 1'b0;
        bus.rx_en        = 1'b0;
        bus.rx_clear     = 1'b0;
        bus.m_ready      = 1'b0;
        bus.overflow_clr = 1'b0;
        #2;
        check_val("rst_valid", 32'(bus.m_valid), 32'd0);
        check_val("rst_level", 32'(bus.level), 32'd0);
        check_val("rst_bit_cnt", 32'(bus.bit_cnt), 32'd0);
        check_val("rst_overflow", 32'(bus.overflow), 32'd0);
        check_val("rst_data", 32'(bus.m_data), 32'd0);
        #10 reset = 1'b1;

        // 1: bits 1,0,1,0 -> 5, then single pop
        drive(1, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        idle(1, 0);
        check_val("t1_valid", 32'(bus.m_valid), 32'd1);
        check_val("t1_data", 32'(bus.m_data), 32'h5);
        check_val("t1_level", 32'(bus.level), 32'd1);
        idle(1, 1);
        idle(1, 0);
        check_val("t1_empty", 32'(bus.m_valid), 32'd0);
        check_val("t1_level0", 32'(bus.level), 32'd0);

        // 2: gapped rx_en with rx toggling while idle -> B
        drive(1, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        idle(1, 0);
        check_val("t2_data", 32'(bus.m_data), 32'hB);
        idle(2, 1);

        // 3: overflow on 5th word, drain, clear
        for (int k = 1; k <= 5; k++) send_word(ser_word_t'(k), 1'b0);
        idle(1, 0);
        check_val("t3_level", 32'(bus.level), 32'd4);
        check_val("t3_overflow", 32'(bus.overflow), 32'd1);
        idle(5, 1);
        idle(1, 0);
        check_val("t3_drained", 32'(bus.level), 32'd0);
        check_val("t3_sticky", 32'(bus.overflow), 32'd1);
        drive(0, 0, 0, 0, 1);
        idle(1, 0);
        check_val("t3_clr", 32'(bus.overflow), 32'd0);

        // 4: 5th word lands on the same edge as a pop
        for (int k = 1; k <= 4; k++) send_word(ser_word_t'(k), 1'b0);
        drive(1, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        drive(1, 0, 0, 1, 0);
        idle(1, 0);
        check_val("t4_level", 32'(bus.level), 32'd4);
        check_val("t4_overflow", 32'(bus.overflow), 32'd0);
        check_val("t4_head", 32'(bus.m_data), 32'h2);
        idle(5, 1);

        // 5: clear aborts a partial word even with rx_en high
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 1, 0, 0);
        drive(1, 0, 0, 0, 0);
        check_val("t5_bit_cnt", 32'(bus.bit_cnt), 32'd0);
        drive(1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        idle(1, 0);
        check_val("t5_data", 32'(bus.m_data), 32'hC);
        idle(2, 1);

        // 6: async reset mid-word with two words queued
        send_word(4'h3, 1'b0);
        send_word(4'h6, 1'b0);
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        idle(1, 0);
        check_val("t6_pre_level", 32'(bus.level), 32'd2);
        #1 reset = 1'b0;
        #1;
        check_val("t6_valid", 32'(bus.m_valid), 32'd0);
        check_val("t6_level", 32'(bus.level), 32'd0);
        check_val("t6_bit_cnt", 32'(bus.bit_cnt), 32'd0);
        check_val("t6_overflow", 32'(bus.overflow), 32'd0);
        #20 reset = 1'b1;
        send_word(4'h9, 1'b0);
        idle(1, 0);
        check_val("t6_data", 32'(bus.m_data), 32'h9);
        idle(2, 1);
        idle(2, 0);
        check_val("final_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
